// File: rtl/alu_drv_pkg.sv
// Shared types and helpers for the adiabatic-slice phase driver.
// Phase gating is selected by defining ALU_DRV_PHASE_GATE_EN.
package alu_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef logic [1:0] quarter_t;

  // The counter parks at the last tick of q3; the result is captured leaving q2.
  localparam quarter_t PARK_Q = 2'd3;
  localparam quarter_t CAP_Q  = 2'd2;

  typedef struct packed {
    logic pos;
    logic neg;
    logic pos2;
    logic neg2;
  } phase_t;

  function automatic phase_t phase_decode(input quarter_t q);
    phase_t p;
    p.pos  = (q == 2'd0) || (q == 2'd1);
    p.pos2 = (q == 2'd1) || (q == 2'd2);
    p.neg  = ~p.pos;
    p.neg2 = ~p.pos2;
    return p;
  endfunction

  function automatic int tick_width(input int qticks);
    return (qticks > 1) ? $clog2(qticks) : 1;
  endfunction

endpackage

// File: rtl/alu_phase_gen.sv
// Tick/quarter counter and registered four-phase power-clock decode.
// With ALU_DRV_PHASE_GATE_EN defined the counter freezes at park unless run_i is high.
module alu_phase_gen
  import alu_drv_pkg::*;
#(
  parameter int QTICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic park_o,
  output logic cap_o,
  output logic clkpos_o,
  output logic clkneg_o,
  output logic clkpos2_o,
  output logic clkneg2_o
);

  localparam int TW = tick_width(QTICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(QTICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  quarter_t      q_q, q_d;
  phase_t        phase_q, phase_d;
  logic          adv;

  assign park_o = (q_q == PARK_Q) && (tick_q == TICK_LAST);
  assign cap_o  = (q_q == CAP_Q)  && (tick_q == TICK_LAST);

`ifdef ALU_DRV_PHASE_GATE_EN
  // Once parked and idle, hold still so the slice sees no power-clock swing.
  assign adv = run_i | ~park_o;
`else
  logic unused_run;
  assign unused_run = run_i;
  assign adv = 1'b1;
`endif

  always_comb begin
    tick_d = tick_q;
    q_d    = q_q;
    if (adv) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        q_d    = q_q + 2'd1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
    phase_d = phase_decode(q_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= TICK_LAST;
      q_q     <= PARK_Q;
      phase_q <= phase_decode(PARK_Q);
    end else begin
      tick_q  <= tick_d;
      q_q     <= q_d;
      phase_q <= phase_d;
    end
  end

  assign clkpos_o  = phase_q.pos;
  assign clkneg_o  = phase_q.neg;
  assign clkpos2_o = phase_q.pos2;
  assign clkneg2_o = phase_q.neg2;

endmodule

// File: rtl/alu_phase_driver.sv
// Operand/result sequencer for the adiabatic datapath slices.
// Define ALU_DRV_PHASE_GATE_EN to stop the phase clocks while idle.
module alu_phase_driver
  import alu_drv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int QTICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  // Both handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both high; valid holds its payload until then, ready may not
  // depend combinationally on valid.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] res_in,
  output logic             clkpos,
  output logic             clkneg,
  output logic             clkpos2,
  output logic             clkneg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output state_e           state_o
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic             accept, capture;
  logic             park, cap;

  alu_phase_gen #(
    .QTICKS (QTICKS)
  ) u_phase_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (state_q != ST_IDLE),
    .park_o    (park),
    .cap_o     (cap),
    .clkpos_o  (clkpos),
    .clkneg_o  (clkneg),
    .clkpos2_o (clkpos2),
    .clkneg2_o (clkneg2)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_ARM;
        end
      end
      // Leaving park lands the counter on q0,t0, so EVAL always sees a full window.
      ST_ARM: begin
        if (park) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (cap) begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        op_a_q <= a;
        op_b_q <= b;
      end
      if (capture) result_q <= res_in;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_phase_driver.sv
// Directed bench for alu_phase_driver; works in both the gated and free-running builds.
`timescale 1ns/1ps
module tb_alu_phase_driver;
  import alu_drv_pkg::*;

  localparam int WIDTH  = 16;
  localparam int QTICKS = 2;
  localparam int PER    = 4 * QTICKS;
  localparam int LAT_MIN = 1 + 3 * QTICKS;
  localparam int LAT_MAX = 7 * QTICKS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] op_a, op_b, res_in, result;
  logic             clkpos, clkneg, clkpos2, clkneg2;
  logic             out_valid;
  logic             out_ready = 1'b0;
  state_e           state_dbg;
  logic             glitch = 1'b0;

  // Slice model: a 16-bit AND array, with an optional glitch override.
  assign res_in = glitch ? 16'hFFFF : (op_a & op_b);

  alu_phase_driver #(.WIDTH(WIDTH), .QTICKS(QTICKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_in    (res_in),
    .clkpos    (clkpos),
    .clkneg    (clkneg),
    .clkpos2   (clkpos2),
    .clkneg2   (clkneg2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .state_o   (state_dbg)
  );

  // Edges since reset release; models the free-running counter position.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  function automatic int pos_of(input int unsigned k);
    return (PER - 1 + int'(k)) % PER;
  endfunction

  // Free-running: EVAL starts at the first edge after e0 landing on position 0.
  function automatic int exp_lat_free(input int unsigned e0);
    return (PER - pos_of(e0)) + 3 * QTICKS;
  endfunction

  function automatic int exp_lat(input int unsigned e0);
`ifdef ALU_DRV_PHASE_GATE_EN
    return (e0 >= 0) ? LAT_MIN : LAT_MIN;
`else
    return exp_lat_free(e0);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        output int unsigned e0, output int lat,
                        output bit stable, output bit tmo);
    int w;
    in_valid = 1'b1;
    a = av;
    b = bv;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    e0 = cyc;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    lat = 0;
    stable = 1'b1;
    while (out_valid !== 1'b1 && lat < 8 * PER) begin
      if (op_a !== av || op_b !== bv) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    tmo = (out_valid !== 1'b1);
  endtask

  task automatic drain(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({clkpos, clkneg, clkpos2, clkneg2} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_phase: got %b expected 0101", {clkpos, clkneg, clkpos2, clkneg2});
    end
    checks++;
    if ({op_a, op_b, result} !== '0) begin
      errors++;
      $display("FAIL reset_regs: op_a=%h op_b=%h result=%h expected all 0", op_a, op_b, result);
    end
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [4:0] obs, exp;
    int q;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      obs = {clkpos, clkneg, clkpos2, clkneg2, in_ready};
`ifdef ALU_DRV_PHASE_GATE_EN
      q = 3;
`else
      q = pos_of(cyc) / QTICKS;
`endif
      exp = {(q < 2), !(q < 2), (q == 1 || q == 2), !(q == 1 || q == 2), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL idle_phase cyc%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_basic_backpressure();
    int unsigned e0;
    int lat;
    bit stable, tmo;
    run_op(16'hF0F0, 16'hFF00, e0, lat, stable, tmo);
    checks++;
    if (tmo || result !== 16'hF000) begin
      errors++;
      $display("FAIL basic_result: got %h valid=%b expected f000", result, out_valid);
    end
    checks++;
    if (lat != exp_lat(e0)) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(e0));
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL basic_op_stable: operands changed, expected f0f0/ff00");
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || result !== 16'hF000 ||
          op_a !== 16'hF0F0 || op_b !== 16'hFF00) begin
        errors++;
        $display("FAIL backpressure_hold %0d: valid=%b ready=%b result=%h expected 1/0/f000",
                 i, out_valid, in_ready, result);
      end
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL handshake_no_accept: in_ready=%b expected 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL after_handshake: valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_glitch();
    int unsigned e0;
    int el;
    repeat (10) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    a = 16'hA5A5;
    b = 16'h0FF0;
    @(posedge clk); #1;
    e0 = cyc;
    in_valid = 1'b0;
    glitch = 1'b1;
    el = exp_lat(e0);
    repeat (el - 1) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_early_valid: valid=%b expected 0", out_valid);
    end
    glitch = 1'b0;
    @(posedge clk); #1;
    glitch = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'h05A0) begin
      errors++;
      $display("FAIL glitch_capture: valid=%b result=%h expected 1/05a0", out_valid, result);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (result !== 16'h05A0) begin
      errors++;
      $display("FAIL glitch_hold: result=%h expected 05a0", result);
    end
    drain(0);
    glitch = 1'b0;
  endtask

  task automatic test_reset_mid_eval();
    int unsigned e0;
    int lat, to_q1;
    bit stable, tmo;
    in_valid = 1'b1;
    a = 16'hC3C3;
    b = 16'h3CFF;
    @(posedge clk); #1;
    e0 = cyc;
    in_valid = 1'b0;
    to_q1 = exp_lat(e0) - 3 * QTICKS + QTICKS;
    repeat (to_q1) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clkpos, clkneg, clkpos2, clkneg2, in_ready, out_valid} !== 6'b010110 ||
        {op_a, op_b, result} !== '0) begin
      errors++;
      $display("FAIL midreset_values: ph=%b ready=%b valid=%b op_a=%h op_b=%h result=%h",
               {clkpos, clkneg, clkpos2, clkneg2}, in_ready, out_valid, op_a, op_b, result);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_valid: valid=%b expected 0", out_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_op(16'h1234, 16'h00FF, e0, lat, stable, tmo);
    checks++;
    if (tmo || result !== 16'h0034) begin
      errors++;
      $display("FAIL post_reset_op: result=%h expected 0034", result);
    end
    checks++;
    if (lat != exp_lat(e0)) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d expected %0d", lat, exp_lat(e0));
    end
    drain(1);
  endtask

  task automatic test_back_to_back();
    int unsigned e0;
    int lat;
    bit stable, tmo;
    logic [WIDTH-1:0] av, bv, exp;
    for (int i = 0; i < 50; i++) begin
      av = WIDTH'($urandom);
      bv = WIDTH'($urandom);
      exp_q.push_back(av & bv);
      run_op(av, bv, e0, lat, stable, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || result !== exp || !stable) begin
        errors++;
        $display("FAIL b2b_result %0d: got %h expected %h (timeout=%0d stable=%0d)",
                 i, result, exp, tmo, stable);
      end
      checks++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
        errors++;
        $display("FAIL b2b_latency_bound %0d: got %0d expected %0d..%0d", i, lat, LAT_MIN, LAT_MAX);
      end
`ifndef ALU_DRV_PHASE_GATE_EN
      checks++;
      if (lat != exp_lat_free(e0)) begin
        errors++;
        $display("FAIL b2b_latency_exact %0d: got %0d expected %0d", i, lat, exp_lat_free(e0));
      end
`endif
      drain($urandom_range(0, 2));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_idle();
    test_basic_backpressure();
    test_glitch();
    test_reset_mid_eval();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
